// File: rtl/matrix_key_scan_if.sv
// Keypad pin and key-event bundle shared between the scanner and its consumer.
// The master side drives the row lines and publishes key events. The slave side drives the columns.
interface matrix_key_scan_if;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic [3:0] key_code;
    logic       key_vld;
    logic       key_pressed;

    modport master (
        input  key_col,
        output key_row,
        output key_code,
        output key_vld,
        output key_pressed
    );

    modport slave (
        output key_col,
        input  key_row,
        input  key_code,
        input  key_vld,
        input  key_pressed
    );
endinterface

// File: rtl/matrix_key_scan.sv
// 4x4 matrix keypad scanner: synchronizes the columns, debounces press and release,
// walks the rows to locate the key, and emits one registered event per press.
module matrix_key_scan #(
    parameter int TIME_20MS = 1000000,
    parameter int TIME_SCAN = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    matrix_key_scan_if.master    kbd
);
    localparam int CNT_MAX = (TIME_20MS > TIME_SCAN) ? TIME_20MS : TIME_SCAN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(TIME_20MS - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(TIME_20MS);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(TIME_SCAN - 1);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, SCAN, HOLD} state_t;

    logic [3:0]       sync_q;
    logic [3:0]       col_s_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       row_q;
    logic [3:0]       key_row_q;
    logic [3:0]       key_code_q;
    logic             key_vld_q;
    logic             key_pressed_q;
    logic             col_act;
    logic [1:0]       col_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 4'hf;
            col_s_q <= 4'hf;
        end else begin
            sync_q  <= kbd.key_col;
            col_s_q <= sync_q;
        end
    end

    // Scanning downward lets the lowest pulled-low column win.
    always_comb begin
        col_act = (col_s_q != 4'hf);
        col_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_s_q[i]) col_idx = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            row_q         <= 2'd0;
            key_row_q     <= 4'h0;
            key_code_q    <= 4'h0;
            key_vld_q     <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            key_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    key_row_q <= 4'h0;
                    if (col_act) begin
                        state_q <= DEBOUNCE;
                        cnt_q   <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (!col_act) begin
                        state_q <= IDLE;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q   <= SCAN;
                        cnt_q     <= '0;
                        row_q     <= 2'd0;
                        key_row_q <= 4'he;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SCAN: begin
                    // Columns are only trusted at the end of the dwell, once the new row drive has synchronized.
                    if (cnt_q == SCAN_LAST) begin
                        cnt_q <= '0;
                        if (col_act) begin
                            state_q       <= HOLD;
                            key_code_q    <= {row_q, col_idx};
                            key_vld_q     <= 1'b1;
                            key_pressed_q <= 1'b1;
                        end else if (row_q == 2'd3) begin
                            state_q   <= IDLE;
                            key_row_q <= 4'h0;
                        end else begin
                            row_q     <= row_q + 2'd1;
                            key_row_q <= ~(4'b0001 << (row_q + 2'd1));
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    // Any column activity is release bounce and restarts the release window.
                    if (col_act) begin
                        cnt_q <= '0;
                    end else if (cnt_q == REL_LAST) begin
                        state_q       <= IDLE;
                        cnt_q         <= '0;
                        key_row_q     <= 4'h0;
                        key_pressed_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign kbd.key_row     = key_row_q;
    assign kbd.key_code    = key_code_q;
    assign kbd.key_vld     = key_vld_q;
    assign kbd.key_pressed = key_pressed_q;
endmodule
